// File: rtl/seg7_scan_driver_if.sv
// Bus between the scan driver and its host/decoder.
// The slave side is the scan driver; the master side is the host that loads
// display data and observes the drive signals.
interface seg7_scan_driver_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [3:0]  hex_out;
  logic [3:0]  an;
  logic        dp;
  logic        frame_tick;

  modport master (
    output value_in, dp_in, blank_in, load,
    input  hex_out, an, dp, frame_tick
  );

  modport slave (
    input  value_in, dp_in, blank_in, load,
    output hex_out, an, dp, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver.
// Cycles through the digits with a dark gap before each one, feeds the
// decoder with the active nibble and double-buffers display data so that a
// new value only takes effect at a frame boundary.
module seg7_scan_driver #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;
  logic          wrap_q;

  logic          pend_q;
  logic [15:0]   pend_value_q;
  logic [3:0]    pend_dp_q;
  logic [3:0]    pend_blank_q;

  logic [15:0]   shadow_value_q;
  logic [3:0]    shadow_dp_q;
  logic [3:0]    shadow_blank_q;

  logic [3:0]    an_d;
  logic          dp_d;
  logic [3:0]    hex_d;

  // State, slot index, slot counter and the frame-boundary marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap;
    end
  end

  // Slot sequencing: dark gap, then the digit, then advance to the next digit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    wrap    = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        if (cnt_q == DIGIT_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          wrap    = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Pending buffer takes host loads; shadow buffer swaps only at the frame
  // boundary. A load on the boundary cycle is kept for the next frame, while
  // the commit uses the pending contents from before that load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q         <= 1'b0;
      pend_value_q   <= '0;
      pend_dp_q      <= '0;
      pend_blank_q   <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '1;
    end else begin
      if (wrap && pend_q) begin
        shadow_value_q <= pend_value_q;
        shadow_dp_q    <= pend_dp_q;
        shadow_blank_q <= pend_blank_q;
      end
      if (bus.load) begin
        pend_q       <= 1'b1;
        pend_value_q <= bus.value_in;
        pend_dp_q    <= bus.dp_in;
        pend_blank_q <= bus.blank_in;
      end else if (wrap) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Drive values for the current slot; hex tracks idx even while dark so the
  // decoder settles before the anode switches on.
  always_comb begin
    an_d  = '1;
    dp_d  = 1'b1;
    hex_d = shadow_value_q[4*idx_q +: 4];
    if (state_q == S_ON && !shadow_blank_q[idx_q]) begin
      an_d = ~(4'b0001 << idx_q);
      dp_d = ~shadow_dp_q[idx_q];
    end
  end

  // Output registers: no combinational path from any input to the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an         <= '1;
      bus.dp         <= 1'b1;
      bus.hex_out    <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.an         <= an_d;
      bus.dp         <= dp_d;
      bus.hex_out    <= hex_d;
      bus.frame_tick <= wrap_q;
    end
  end

endmodule
